// File: rtl/serial_async_pkg.sv
// Shared types and helpers for the asynchronous serial transmitter/receiver pair.
package serial_async_pkg;

  typedef enum logic [2:0] {
    Ready      = 3'd0,
    RecvStart  = 3'd1,
    RecvData   = 3'd2,
    RecvParity = 3'd3,
    RecvStop   = 3'd4
  } t_rx_state;

  // Main-clock cycles per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned main_hz,
                                               input int unsigned serial_hz);
    return main_hz / serial_hz;
  endfunction

endpackage

// File: rtl/serial_async_rx_sync_ff.sv
// Generic multi-flop synchroniser for a single asynchronous bit.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) chain_q <= {STAGES{RESET_VAL}};
    else        chain_q <= {chain_q[STAGES-2:0], d};
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/serial_async_rx.sv
// Oversampling asynchronous serial receiver with parity and framing checks.
module serial_async_rx
  import serial_async_pkg::*;
#(
  parameter int unsigned MAIN_CLK_HZ          = 50_000_000,
  parameter int unsigned SERIAL_CLK_HZ        = 9_600,
  parameter logic        SERIAL_DATA_INACTIVE = 1'b1,
  parameter int unsigned BITS                 = 8,
  parameter int unsigned START_BITS           = 1,
  parameter int unsigned PARITY_BITS          = 0,
  parameter logic        PARITY_ODD           = 1'b0,
  parameter int unsigned STOP_BITS            = 1,
  parameter logic        LOWBIT_FIRST         = 1'b1,
  parameter int unsigned SYNC_STAGES          = 2
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial,
  output logic            out_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_parallel,
  output logic            out_frame_err,
  output logic            out_parity_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(MAIN_CLK_HZ, SERIAL_CLK_HZ);
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_W        = $clog2(BITS) + 1;

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("serial_async_rx: CLKS_PER_BIT must be at least 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("serial_async_rx: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic              line_s;
  t_rx_state         state_q, state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [BIT_W-1:0]  bit_q;
  logic [BIT_W-1:0]  data_pos;
  logic [BITS-1:0]   shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              tick;
  logic              deliver;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (SERIAL_DATA_INACTIVE)
  ) u_sync (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .d      (in_serial),
    .q      (line_s)
  );

  // Next-state logic: sampling decisions at each baud-counter expiry.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    deliver      = 1'b0;
    tick         = (baud_q == BAUD_W'(1));
    data_pos     = LOWBIT_FIRST ? bit_q : (BIT_W'(BITS - 1) - bit_q);
    case (state_q)
      Ready: begin
        if (line_s != SERIAL_DATA_INACTIVE) begin
          state_d      = RecvStart;
          frame_err_d  = 1'b0;
          parity_err_d = 1'b0;
        end
      end
      RecvStart: begin
        if (tick) begin
          // An idle level on the first start sample means the edge was a glitch.
          if (bit_q == '0 && line_s == SERIAL_DATA_INACTIVE) begin
            state_d = Ready;
          end else begin
            if (line_s == SERIAL_DATA_INACTIVE) frame_err_d = 1'b1;
            if (bit_q == BIT_W'(START_BITS - 1)) state_d = RecvData;
          end
        end
      end
      RecvData: begin
        if (tick) begin
          for (int unsigned i = 0; i < BITS; i++) begin
            if (BIT_W'(i) == data_pos) shift_d[i] = line_s;
          end
          if (bit_q == BIT_W'(BITS - 1)) state_d = (PARITY_BITS != 0) ? RecvParity : RecvStop;
        end
      end
      RecvParity: begin
        if (tick) begin
          parity_err_d = (((^shift_q) ^ line_s) != PARITY_ODD);
          state_d      = RecvStop;
        end
      end
      RecvStop: begin
        if (tick) begin
          if (line_s == 1'b0) frame_err_d = 1'b1;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = Ready;
            deliver = 1'b1;
          end
        end
      end
      default: state_d = Ready;
    endcase
  end

  // Idle indication decoded from the state register.
  always_comb begin
    out_ready = (state_q == Ready);
  end

  // State, counters, shift register, error latches and delivered outputs.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q        <= Ready;
      baud_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      frame_err_q    <= 1'b0;
      parity_err_q   <= 1'b0;
      out_valid      <= 1'b0;
      out_parallel   <= '0;
      out_frame_err  <= 1'b0;
      out_parity_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      out_valid    <= deliver;
      // Half-bit preload puts every later sample in the middle of its bit.
      if (state_q == Ready) baud_q <= (state_d == RecvStart) ? BAUD_W'(CLKS_PER_BIT / 2) : '0;
      else if (tick)        baud_q <= BAUD_W'(CLKS_PER_BIT);
      else                  baud_q <= baud_q - BAUD_W'(1);
      if (state_d != state_q)              bit_q <= '0;
      else if (tick && state_q != Ready)   bit_q <= bit_q + BIT_W'(1);
      if (deliver) begin
        out_parallel   <= shift_q;
        out_frame_err  <= frame_err_d;
        out_parity_err <= (PARITY_BITS != 0) ? parity_err_q : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_async_rx.sv
// Bench for serial_async_rx: three receiver configurations driven by a bit-level line model.
module tb_serial_async_rx;

  localparam int unsigned CPB  = 10;
  localparam int unsigned SYNC = 2;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       fe;
    logic       pe;
    longint     bf;
    longint     be;
    bit         strobe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser [3];
  logic       rdy [3];
  logic       v   [3];
  logic       fe  [3];
  logic       pe  [3];
  logic [7:0] pw  [3];

  longint     cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         matched = 0;
  int         n_expected = 0;
  exp_t       q[$];

  logic [7:0] last_word [3] = '{default: 8'h00};
  logic [7:0] cap_d     [3] = '{default: 8'h00};
  logic       cap_fe    [3] = '{default: 1'b0};
  logic       cap_pe    [3] = '{default: 1'b0};
  longint     strobe_cyc      [3] = '{default: 0};
  longint     prev_strobe_cyc [3] = '{default: 0};
  int         nstrobe   [3] = '{default: 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: 8N1 LSB first, dut1: 8E1, dut2: 8N1 MSB first
  serial_async_rx #(.MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(100_000)) u_dut0 (
    .in_clk(clk), .in_rst(rst), .in_serial(ser[0]), .out_ready(rdy[0]), .out_valid(v[0]),
    .out_parallel(pw[0]), .out_frame_err(fe[0]), .out_parity_err(pe[0]));

  serial_async_rx #(.MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(100_000),
                    .PARITY_BITS(1), .PARITY_ODD(1'b0)) u_dut1 (
    .in_clk(clk), .in_rst(rst), .in_serial(ser[1]), .out_ready(rdy[1]), .out_valid(v[1]),
    .out_parallel(pw[1]), .out_frame_err(fe[1]), .out_parity_err(pe[1]));

  serial_async_rx #(.MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(100_000),
                    .LOWBIT_FIRST(1'b0)) u_dut2 (
    .in_clk(clk), .in_rst(rst), .in_serial(ser[2]), .out_ready(rdy[2]), .out_valid(v[2]),
    .out_parallel(pw[2]), .out_frame_err(fe[2]), .out_parity_err(pe[2]));

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every receiver against the expected-frame list.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit   busy;
      bit   hit;
      exp_t e;
      busy = 1'b0;
      hit  = 1'b0;
      e    = '{default: 0};
      if (rst) last_word[k] = 8'h00;
      foreach (q[j]) begin
        if (q[j].k == k && q[j].bf <= cyc && cyc < q[j].be) busy = 1'b1;
        if (q[j].k == k && q[j].strobe && q[j].be == cyc) begin
          hit = 1'b1;
          e   = q[j];
        end
      end
      check("ready", k, 64'(rdy[k]), 64'(!busy));
      if (hit) begin
        check("strobe", k, 64'(v[k]), 64'(1'b1));
        check("data", k, 64'(pw[k]), 64'(e.d));
        check("frame_err", k, 64'(fe[k]), 64'(e.fe));
        check("parity_err", k, 64'(pe[k]), 64'(e.pe));
        last_word[k]       = e.d;
        cap_d[k]           = pw[k];
        cap_fe[k]          = fe[k];
        cap_pe[k]          = pe[k];
        prev_strobe_cyc[k] = strobe_cyc[k];
        strobe_cyc[k]      = cyc;
        nstrobe[k]++;
        matched++;
      end else begin
        check("no_strobe", k, 64'(v[k]), 64'(1'b0));
        check("hold", k, 64'(pw[k]), 64'(last_word[k]));
      end
    end
  end

  task automatic tx_bit(input int k, input logic b, input int unsigned n);
    ser[k] = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame and records when and what the receiver must deliver.
  task automatic send_frame(input int k, input logic [7:0] d, input bit lsb_first,
                            input bit has_par, input logic par_bit, input logic stop_lvl);
    exp_t        e;
    int unsigned nbits;
    nbits    = 2 + 8 + (has_par ? 1 : 0);
    e.k      = k;
    e.d      = d;
    e.fe     = !stop_lvl;
    e.pe     = has_par && (((^d) ^ par_bit) != 1'b0);
    e.bf     = cyc + SYNC + 1;
    e.be     = cyc + SYNC + longint'(nbits * CPB - CPB / 2 + 1);
    e.strobe = 1'b1;
    q.push_back(e);
    n_expected++;
    tx_bit(k, 1'b0, CPB);
    for (int i = 0; i < 8; i++) tx_bit(k, lsb_first ? d[i] : d[7-i], CPB);
    if (has_par) tx_bit(k, par_bit, CPB);
    if (stop_lvl) begin
      tx_bit(k, 1'b1, CPB);
    end else begin
      // Low across the mid-bit sample, idle again before the receiver re-arms.
      tx_bit(k, 1'b0, 6);
      tx_bit(k, 1'b1, CPB - 6);
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t       e;
    logic [7:0] words [3];
    words = '{8'h01, 8'h80, 8'hFF};
    for (int k = 0; k < 3; k++) ser[k] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", k, 64'(rdy[k]), 64'(1'b1));
      check("rst_valid", k, 64'(v[k]), 64'(1'b0));
      check("rst_data", k, 64'(pw[k]), 64'(8'h00));
      check("rst_fe", k, 64'(fe[k]), 64'(1'b0));
      check("rst_pe", k, 64'(pe[k]), 64'(1'b0));
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // plain 8N1 frame
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check("t1_data", 0, 64'(cap_d[0]), 64'(8'hA5));
    check("t1_fe", 0, 64'(cap_fe[0]), 64'(1'b0));
    check("t1_pe", 0, 64'(cap_pe[0]), 64'(1'b0));
    check("t1_count", 0, 64'(nstrobe[0]), 64'(1));
    check("t1_ready", 0, 64'(rdy[0]), 64'(1'b1));

    // short low pulse: receiver must fall back to idle at the first start sample
    e = '{k: 0, d: 8'h00, fe: 1'b0, pe: 1'b0, bf: cyc + SYNC + 1,
          be: cyc + SYNC + 1 + CPB / 2, strobe: 1'b0};
    q.push_back(e);
    tx_bit(0, 1'b0, 3);
    tx_bit(0, 1'b1, 30);
    check("t2_count", 0, 64'(nstrobe[0]), 64'(1));
    check("t2_ready", 0, 64'(rdy[0]), 64'(1'b1));

    // bad stop bit
    send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("t3_data", 0, 64'(cap_d[0]), 64'(8'h3C));
    check("t3_fe", 0, 64'(cap_fe[0]), 64'(1'b1));

    // even parity: 0x07 has three ones, so parity bit 1 is correct
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check("t4a_pe", 1, 64'(cap_pe[1]), 64'(1'b0));
    check("t4a_data", 1, 64'(cap_d[1]), 64'(8'h07));
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    check("t4b_pe", 1, 64'(cap_pe[1]), 64'(1'b1));
    check("t4b_data", 1, 64'(cap_d[1]), 64'(8'h07));
    check("t4b_fe", 1, 64'(cap_fe[1]), 64'(1'b0));

    // back-to-back frames
    send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check("t5_gap", 0, 64'(strobe_cyc[0] - prev_strobe_cyc[0]), 64'(100));
    check("t5_data", 0, 64'(cap_d[0]), 64'(8'hAA));
    check("t5_count", 0, 64'(nstrobe[0]), 64'(4));

    // reset during data bit 4, then a clean frame
    e = '{k: 0, d: 8'h00, fe: 1'b0, pe: 1'b0, bf: cyc + SYNC + 1,
          be: cyc + 5 * CPB + 3, strobe: 1'b0};
    q.push_back(e);
    tx_bit(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) tx_bit(0, 1'b0, CPB);
    tx_bit(0, 1'b1, 3);
    rst = 1'b1;
    ser[0] = 1'b1;
    #1;
    check("t6_ready", 0, 64'(rdy[0]), 64'(1'b1));
    check("t6_valid", 0, 64'(v[0]), 64'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check("t6_data", 0, 64'(cap_d[0]), 64'(8'h81));
    check("t6_count", 0, 64'(nstrobe[0]), 64'(5));

    // MSB-first line, as produced by a transmitter with LOWBIT_FIRST=0
    for (int i = 0; i < 3; i++) begin
      send_frame(2, words[i], 1'b0, 1'b0, 1'b0, 1'b1);
      settle();
      check("t7_data", 2, 64'(cap_d[2]), 64'(words[i]));
    end
    check("t7_count", 2, 64'(nstrobe[2]), 64'(3));

    check("all_delivered", 0, 64'(matched), 64'(n_expected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
